// File: rtl/dev_defines.sv
// dev_defines: shared definitions for the device interrupt controller.
//   N_SRC_DEFAULT : default number of interrupt sources
//   REG_*         : register word index as decoded from addr[3:2]
//                   (MASK 0x0, PENDING 0x4, CAUSE 0x8, reserved 0xC)
//   state_t       : service FSM states
package dev_defines;

    localparam int N_SRC_DEFAULT = 8;

    localparam logic [1:0] REG_MASK    = 2'd0;
    localparam logic [1:0] REG_PENDING = 2'd1;
    localparam logic [1:0] REG_CAUSE   = 2'd2;
    localparam logic [1:0] REG_RSVD    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FIN    = 2'd2
    } state_t;

endpackage

// File: rtl/int_prio_arbiter.sv
// int_prio_arbiter: combinational winner selection for the interrupt controller.
// Searches req_vec starting at the index just after ptr and wrapping, so the
// first asserted index following ptr wins. Fixed lowest-index priority is the
// special case ptr = N_SRC-1.
//   req_vec : masked request vector
//   ptr     : last serviced id (search starts at ptr+1)
//   id      : winning index (0 when valid = 0)
//   valid   : at least one request asserted
module int_prio_arbiter #(
    parameter int N_SRC = 8
) (
    input  logic [N_SRC-1:0] req_vec,
    input  logic [3:0]       ptr,
    output logic [3:0]       id,
    output logic             valid
);

    localparam int IW = $clog2(N_SRC);

    logic [IW-1:0] idx;

    // Walk the N_SRC candidates in rotated order; the first hit is kept.
    always_comb begin
        id    = '0;
        valid = 1'b0;
        idx   = '0;
        for (int k = 1; k <= N_SRC; k++) begin
            idx = IW'((int'(ptr) + k) % N_SRC);
            if (!valid && req_vec[idx]) begin
                valid = 1'b1;
                id    = 4'(idx);
            end
        end
    end

endmodule

// File: rtl/dev_int_ctrl.sv
// dev_int_ctrl: device interrupt controller with a small register window.
// Optional feature: define DEV_INT_CTRL_ROUND_ROBIN_EN for round-robin
// arbitration; otherwise the lowest asserted index wins and no pointer
// register exists.
//   clk, rstn           : clock, asynchronous active-low reset
//   req/we/be/addr/wdata: bus request into the register window
//   rdata/ack           : registered read data and acknowledge (req + 1 cycle)
//   src_req_i           : level requests from devices
//   src_fin_o           : one-cycle completion pulse to the serviced device
//   irq_o/irq_id_o      : interrupt to the core and the id being serviced
//   int_fin_i           : core pulse marking end of service
module dev_int_ctrl
    import dev_defines::*;
#(
    parameter int N_SRC = N_SRC_DEFAULT
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             ack,
    input  logic [N_SRC-1:0] src_req_i,
    output logic [N_SRC-1:0] src_fin_o,
    output logic             irq_o,
    output logic [3:0]       irq_id_o,
    input  logic             int_fin_i
);

    state_t           state;
    state_t           state_next;
    logic [3:0]       id;
    logic [3:0]       id_next;
    logic [N_SRC-1:0] mask;
    logic [N_SRC-1:0] pending;
    logic [31:0]      mask_ext;
    logic [31:0]      byte_mask;
    logic [31:0]      mask_wr;
    logic [31:0]      rd_mux;
    logic [3:0]       rr_ptr;
    logic [3:0]       win_id;
    logic             win_valid;
    logic             busy;
    logic             unused_bits;

    assign pending  = src_req_i & mask;
    assign mask_ext = {{(32-N_SRC){1'b0}}, mask};
    assign busy     = (state != ST_IDLE);
    assign irq_id_o = id;

    // Byte-enable merge: untouched bytes keep their old MASK value.
    assign byte_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    assign mask_wr   = (mask_ext & ~byte_mask) | (wdata & byte_mask);

    assign unused_bits = ^{addr[31:4], addr[1:0], mask_wr};

    int_prio_arbiter #(
        .N_SRC (N_SRC)
    ) u_arb (
        .req_vec (pending),
        .ptr     (rr_ptr),
        .id      (win_id),
        .valid   (win_valid)
    );

`ifdef DEV_INT_CTRL_ROUND_ROBIN_EN
    // Remembers the last granted id so the next search starts just after it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr <= 4'(N_SRC - 1);
        end else if (state == ST_IDLE && win_valid) begin
            rr_ptr <= win_id;
        end
    end
`else
    // Searching after N_SRC-1 wraps to index 0, i.e. lowest index wins.
    assign rr_ptr = 4'(N_SRC - 1);
`endif

    always_comb begin
        rd_mux = '0;
        case (addr[3:2])
            REG_MASK:    rd_mux = mask_ext;
            REG_PENDING: rd_mux = {{(32-N_SRC){1'b0}}, pending};
            REG_CAUSE:   rd_mux = {busy, 27'd0, id};
            REG_RSVD:    rd_mux = '0;
        endcase
    end

    // Arbitration reads mask before this edge's write lands, so a write and
    // a grant on the same edge naturally use the old MASK.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ack   <= 1'b0;
            rdata <= '0;
            mask  <= '0;
        end else begin
            ack   <= req;
            rdata <= (req && !we) ? rd_mux : 32'd0;
            if (req && we && addr[3:2] == REG_MASK) begin
                mask <= mask_wr[N_SRC-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
            id    <= '0;
        end else begin
            state <= state_next;
            id    <= id_next;
        end
    end

    // irq_o and src_fin_o decode from state, so an async reset removes them
    // at once. Once ACTIVE, only int_fin_i ends service regardless of mask or
    // request changes; the completion pulse is the single FIN cycle.
    always_comb begin
        state_next = state;
        id_next    = id;
        irq_o      = 1'b0;
        src_fin_o  = '0;
        case (state)
            ST_IDLE: begin
                if (win_valid) begin
                    state_next = ST_ACTIVE;
                    id_next    = win_id;
                end
            end
            ST_ACTIVE: begin
                irq_o = 1'b1;
                if (int_fin_i) begin
                    state_next = ST_FIN;
                end
            end
            ST_FIN: begin
                for (int i = 0; i < N_SRC; i++) begin
                    src_fin_o[i] = (id == 4'(i));
                end
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dev_int_ctrl.sv
// tb_dev_int_ctrl: directed self-checking bench for dev_int_ctrl (N_SRC = 8).
// Follows DEV_INT_CTRL_ROUND_ROBIN_EN for the expected service order.
module tb_dev_int_ctrl;

    localparam int N_SRC = 8;

    logic             clk       = 1'b0;
    logic             rstn      = 1'b0;
    logic             req       = 1'b0;
    logic             we        = 1'b0;
    logic [3:0]       be        = 4'h0;
    logic [31:0]      addr      = 32'h0;
    logic [31:0]      wdata     = 32'h0;
    logic [31:0]      rdata;
    logic             ack;
    logic [N_SRC-1:0] src_req_i = '0;
    logic [N_SRC-1:0] src_fin_o;
    logic             irq_o;
    logic [3:0]       irq_id_o;
    logic             int_fin_i = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dev_int_ctrl #(
        .N_SRC (N_SRC)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req       (req),
        .we        (we),
        .be        (be),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .ack       (ack),
        .src_req_i (src_req_i),
        .src_fin_o (src_fin_o),
        .irq_o     (irq_o),
        .irq_id_o  (irq_id_o),
        .int_fin_i (int_fin_i)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        req   = 1'b1;
        we    = 1'b1;
        addr  = a;
        wdata = d;
        be    = b;
        tick();
        req = 1'b0;
        we  = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        req  = 1'b1;
        we   = 1'b0;
        addr = a;
        tick();
        d   = rdata;
        req = 1'b0;
    endtask

    task automatic fin_pulse();
        int_fin_i = 1'b1;
        tick();
        int_fin_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rstn = 1'b0;
        tick();
        tick();
        checks++; if (irq_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq: got %0b want 0", irq_o); end
        checks++; if (irq_id_o !== 4'd0) begin errors++; $display("[TB] FAIL reset_id: got %0d want 0", irq_id_o); end
        checks++; if (src_fin_o !== 8'h00) begin errors++; $display("[TB] FAIL reset_fin: got %h want 00", src_fin_o); end
        checks++; if (ack !== 1'b0) begin errors++; $display("[TB] FAIL reset_ack: got %0b want 0", ack); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata: got %h want 0", rdata); end
        rstn = 1'b1;
        tick();
        bus_read(32'h0, d);
        checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL reset_mask: got %h want 0", d); end
    endtask

    task automatic test_basic();
        bus_write(32'h0, 32'h05, 4'hF);
        src_req_i = 8'h04;
        tick();
        checks++; if (irq_o !== 1'b1) begin errors++; $display("[TB] FAIL basic_irq: got %0b want 1", irq_o); end
        checks++; if (irq_id_o !== 4'd2) begin errors++; $display("[TB] FAIL basic_id: got %0d want 2", irq_id_o); end
        checks++; if (src_fin_o !== 8'h00) begin errors++; $display("[TB] FAIL basic_fin_early: got %h want 00", src_fin_o); end
        fin_pulse();
        checks++; if (src_fin_o !== 8'h04) begin errors++; $display("[TB] FAIL basic_fin: got %h want 04", src_fin_o); end
        checks++; if (irq_o !== 1'b0) begin errors++; $display("[TB] FAIL basic_irq_clr: got %0b want 0", irq_o); end
        src_req_i = 8'h00;
        tick();
        checks++; if (src_fin_o !== 8'h00) begin errors++; $display("[TB] FAIL basic_fin_len: got %h want 00", src_fin_o); end
    endtask

    task automatic test_priority();
        bus_write(32'h0, 32'hFF, 4'hF);
        src_req_i = 8'h90;
        tick();
        checks++; if (irq_id_o !== 4'd4 || irq_o !== 1'b1) begin errors++; $display("[TB] FAIL prio_first: got id %0d irq %0b want id 4 irq 1", irq_id_o, irq_o); end
        fin_pulse();
        checks++; if (src_fin_o !== 8'h10) begin errors++; $display("[TB] FAIL prio_fin4: got %h want 10", src_fin_o); end
        src_req_i = 8'h80;
        tick();
        checks++; if (irq_o !== 1'b0) begin errors++; $display("[TB] FAIL prio_no_arb_in_fin: got irq %0b want 0", irq_o); end
        tick();
        checks++; if (irq_id_o !== 4'd7 || irq_o !== 1'b1) begin errors++; $display("[TB] FAIL prio_second: got id %0d irq %0b want id 7 irq 1", irq_id_o, irq_o); end
        fin_pulse();
        checks++; if (src_fin_o !== 8'h80) begin errors++; $display("[TB] FAIL prio_fin7: got %h want 80", src_fin_o); end
        src_req_i = 8'h00;
        tick();
        fin_pulse();
        checks++; if (irq_o !== 1'b0 || src_fin_o !== 8'h00) begin errors++; $display("[TB] FAIL fin_in_idle: got irq %0b fin %h want 0 00", irq_o, src_fin_o); end
    endtask

    task automatic test_mask_be();
        logic [31:0] d;
        bus_write(32'h0, 32'h0, 4'hF);
        tick();
        req   = 1'b1;
        we    = 1'b1;
        addr  = 32'h0;
        wdata = 32'hFFFF_FFFF;
        be    = 4'b0001;
        checks++; if (ack !== 1'b0) begin errors++; $display("[TB] FAIL ack_before: got %0b want 0", ack); end
        tick();
        req = 1'b0;
        we  = 1'b0;
        checks++; if (ack !== 1'b1) begin errors++; $display("[TB] FAIL ack_after: got %0b want 1", ack); end
        tick();
        checks++; if (ack !== 1'b0) begin errors++; $display("[TB] FAIL ack_len: got %0b want 0", ack); end
        bus_read(32'h0, d);
        checks++; if (d !== 32'h0000_00FF) begin errors++; $display("[TB] FAIL mask_be0: got %h want 000000ff", d); end
        bus_write(32'h0, 32'h0000_0000, 4'b1110);
        bus_read(32'h0, d);
        checks++; if (d !== 32'h0000_00FF) begin errors++; $display("[TB] FAIL mask_be_hi: got %h want 000000ff", d); end
        bus_write(32'hC, 32'hFFFF_FFFF, 4'hF);
        bus_read(32'hC, d);
        checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL rsvd_read: got %h want 0", d); end
        bus_write(32'h0, 32'h0, 4'hF);
    endtask

    task automatic test_mask_race();
        src_req_i = 8'h01;
        tick();
        checks++; if (irq_o !== 1'b0) begin errors++; $display("[TB] FAIL race_masked: got %0b want 0", irq_o); end
        bus_write(32'h0, 32'h01, 4'hF);
        checks++; if (irq_o !== 1'b0) begin errors++; $display("[TB] FAIL race_old_mask: got %0b want 0", irq_o); end
        tick();
        checks++; if (irq_o !== 1'b1 || irq_id_o !== 4'd0) begin errors++; $display("[TB] FAIL race_grant: got irq %0b id %0d want 1 0", irq_o, irq_id_o); end
        fin_pulse();
        src_req_i = 8'h00;
        checks++; if (src_fin_o !== 8'h01) begin errors++; $display("[TB] FAIL race_fin: got %h want 01", src_fin_o); end
        tick();
    endtask

    task automatic test_mask_clear();
        logic [31:0] d;
        bus_write(32'h0, 32'h05, 4'hF);
        src_req_i = 8'h04;
        tick();
        bus_read(32'h8, d);
        checks++; if (d !== 32'h8000_0002) begin errors++; $display("[TB] FAIL cause_active: got %h want 80000002", d); end
        bus_read(32'h4, d);
        checks++; if (d !== 32'h0000_0004) begin errors++; $display("[TB] FAIL pending: got %h want 00000004", d); end
        bus_write(32'h0, 32'h0, 4'hF);
        bus_read(32'h4, d);
        checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL pending_masked: got %h want 0", d); end
        src_req_i = 8'h00;
        tick();
        tick();
        checks++; if (irq_o !== 1'b1 || irq_id_o !== 4'd2) begin errors++; $display("[TB] FAIL clear_hold: got irq %0b id %0d want 1 2", irq_o, irq_id_o); end
        bus_read(32'h8, d);
        checks++; if (d !== 32'h8000_0002) begin errors++; $display("[TB] FAIL cause_hold: got %h want 80000002", d); end
        fin_pulse();
        checks++; if (src_fin_o !== 8'h04 || irq_o !== 1'b0) begin errors++; $display("[TB] FAIL clear_fin: got fin %h irq %0b want 04 0", src_fin_o, irq_o); end
        tick();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_order [4];
        logic [7:0] exp_fin;
        bit         got;
`ifdef DEV_INT_CTRL_ROUND_ROBIN_EN
        exp_order = '{4'd1, 4'd3, 4'd1, 4'd3};
`else
        exp_order = '{4'd1, 4'd1, 4'd1, 4'd1};
`endif
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        bus_write(32'h0, 32'h0A, 4'hF);
        src_req_i = 8'h0A;
        for (int n = 0; n < 4; n++) begin
            got = 1'b0;
            for (int c = 0; c < 6 && !got; c++) begin
                tick();
                if (irq_o === 1'b1) got = 1'b1;
            end
            checks++;
            if (!got) begin
                errors++;
                $display("[TB] FAIL rr_timeout: service %0d got no irq want id %0d", n, exp_order[n]);
            end else if (irq_id_o !== exp_order[n]) begin
                errors++;
                $display("[TB] FAIL rr_order: service %0d got id %0d want %0d", n, irq_id_o, exp_order[n]);
            end
            fin_pulse();
            exp_fin = 8'h01 << exp_order[n];
            checks++; if (src_fin_o !== exp_fin) begin errors++; $display("[TB] FAIL rr_fin: service %0d got %h want %h", n, src_fin_o, exp_fin); end
        end
        src_req_i = 8'h00;
        tick();
    endtask

    task automatic test_reset_active();
        logic [31:0] d;
        bus_write(32'h0, 32'h04, 4'hF);
        src_req_i = 8'h04;
        tick();
        checks++; if (irq_o !== 1'b1) begin errors++; $display("[TB] FAIL rst_pre_irq: got %0b want 1", irq_o); end
        rstn = 1'b0;
        #1;
        checks++; if (irq_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_irq_async: got %0b want 0", irq_o); end
        checks++; if (src_fin_o !== 8'h00) begin errors++; $display("[TB] FAIL rst_fin_async: got %h want 00", src_fin_o); end
        int_fin_i = 1'b1;
        tick();
        int_fin_i = 1'b0;
        checks++; if (src_fin_o !== 8'h00) begin errors++; $display("[TB] FAIL rst_fin_hold: got %h want 00", src_fin_o); end
        rstn = 1'b1;
        tick();
        checks++; if (irq_o !== 1'b0 || src_fin_o !== 8'h00) begin errors++; $display("[TB] FAIL rst_after: got irq %0b fin %h want 0 00", irq_o, src_fin_o); end
        bus_read(32'h0, d);
        checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL rst_mask: got %h want 0", d); end
        src_req_i = 8'h00;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_mask_be();
        test_mask_race();
        test_mask_clear();
        test_round_robin();
        test_reset_active();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
